// File: rtl/inst_fetch.sv
// Fetch stage: reads one instruction per PC over req/rdy, hands it to decode, then advances/redirects the PC.
// Define IFETCH_STALL_CNT_EN to add the saturating stall_cycles counter output.
module inst_fetch #(
  parameter logic [3:0]  JUMP_OPCODE    = 4'hC,
  parameter logic [3:0]  HALT_OPCODE    = 4'hF,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        Clk2,
  input  logic        reset,
  input  logic [15:0] PC,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic        updatePC,
  output logic        jump,
  output logic [11:0] offset,
  output logic        halted,
  output logic        fetch_err
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, ADV, HALT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  timeout_cnt;
  logic        first_req;
  logic [15:0] addr_hold;
  logic [3:0]  opcode;

  assign opcode = instr[15:12];

  // The PC unit updates on the same edge that enters REQ, so the first REQ
  // cycle passes the fresh PC through and latches it for the remaining cycles.
  assign imem_addr = first_req ? PC : addr_hold;

  always_ff @(posedge Clk2) begin
    if (reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      updatePC    <= 1'b0;
      jump        <= 1'b0;
      offset      <= 12'h000;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      timeout_cnt <= 8'd0;
      first_req   <= 1'b0;
      addr_hold   <= 16'h0000;
    end else begin
      updatePC  <= 1'b0;
      jump      <= 1'b0;
      offset    <= 12'h000;
      first_req <= 1'b0;
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          first_req <= 1'b1;
        end
        REQ: begin
          if (first_req) addr_hold <= PC;
          if (imem_rdy && imem_req) begin
            instr       <= imem_data;
            timeout_cnt <= 8'd0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            halted    <= 1'b1;
            state     <= HALT;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (decode_ready) begin
            instr_valid <= 1'b0;
            if (opcode == HALT_OPCODE) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              updatePC <= 1'b1;
              jump     <= (opcode == JUMP_OPCODE);
              offset   <= (opcode == JUMP_OPCODE) ? instr[11:0] : 12'h000;
              state    <= ADV;
            end
          end
        end
        ADV: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          first_req <= 1'b1;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  // Memory wait cycles plus decode back-pressure cycles, saturating.
  always_ff @(posedge Clk2) begin
    if (reset) begin
      stall_cycles <= 16'h0000;
    end else if ((((state == REQ) && !imem_rdy) || ((state == HOLD) && !decode_ready))
                 && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized memory latency and decode back-pressure.
module tb_inst_fetch;

  localparam int TO = 64;

  logic        Clk2;
  logic        reset;
  logic [15:0] PC;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        decode_ready;
  logic        updatePC;
  logic        jump;
  logic [11:0] offset;
  logic        halted;
  logic        fetch_err;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  inst_fetch dut (
    .Clk2(Clk2), .reset(reset), .PC(PC),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .decode_ready(decode_ready),
    .updatePC(updatePC), .jump(jump), .offset(offset),
    .halted(halted), .fetch_err(fetch_err)
`ifdef IFETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    Clk2 = 1'b0;
    forever #5 Clk2 = ~Clk2;
  end

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  // Environment knobs
  int wait_max  = 0;
  int wait_left = 0;
  int dr_pct    = 100;
  bit dr_hold   = 1'b0;
  bit rdy_stuck = 1'b0;

  // Reference model: program-order PC plus handshake expectations
  logic [15:0] m_pc;
  logic [15:0] adv_instr;
  logic [15:0] m_stall;
  bit exp_req, exp_valid, adv_due, m_halted, m_err;
  int req_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle of txn %0d)", tag, got, exp, n_txn);
  endtask

  function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [15:0] ins);
    if (ins[15:12] == 4'hC) return pc + 16'($signed(ins[11:0]));
    return pc + 16'd1;
  endfunction

  task automatic do_reset(input logic [15:0] start);
    reset        = 1'b1;
    PC           = start;
    decode_ready = 1'b0;
    imem_rdy     = 1'b1;
    imem_data    = 16'($urandom);
    repeat (2) @(negedge Clk2);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_upd", updatePC, 0);
    check("rst_jump", jump, 0);
    check("rst_offset", offset, 0);
    check("rst_halted", halted, 0);
    check("rst_err", fetch_err, 0);
    reset     = 1'b0;
    imem_rdy  = 1'b1;  // late rdy while leaving reset must be ignored
    m_pc      = start;
    adv_instr = 16'h0000;
    m_stall   = 16'h0000;
    exp_req   = 1'b1;
    exp_valid = 1'b0;
    adv_due   = 1'b0;
    m_halted  = 1'b0;
    m_err     = 1'b0;
    req_wait  = 0;
    wait_left = 0;
  endtask

  task automatic step();
    bit rdy_q, accept, new_adv, halt_now;
    logic [15:0] cur;
    @(negedge Clk2);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) check("instr", instr, mem[m_pc]);
    check("updatePC", updatePC, adv_due);
    check("jump", jump, adv_due && adv_instr[15:12] == 4'hC);
    check("offset", offset, (adv_due && adv_instr[15:12] == 4'hC) ? adv_instr[11:0] : 12'h000);
    check("halted", halted, m_halted);
    check("fetch_err", fetch_err, m_err);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
    // PC unit
    if (updatePC) PC = jump ? PC + {{4{offset[11]}}, offset} : PC + 16'd1;
    // Instruction memory
    if (imem_req && !rdy_stuck) begin
      if (wait_left > 0) begin
        imem_rdy = 1'b0;
        wait_left--;
      end else begin
        imem_rdy  = 1'b1;
        imem_data = mem[imem_addr];
      end
    end else begin
      imem_rdy  = rdy_stuck ? 1'b0 : 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
      wait_left = $urandom_range(0, wait_max);
    end
    decode_ready = !dr_hold && ($urandom_range(0, 99) < dr_pct);
    // Model advance
    rdy_q    = exp_req && imem_rdy;
    accept   = exp_valid && decode_ready;
    new_adv  = 1'b0;
    halt_now = 1'b0;
    if (((exp_req && !imem_rdy) || (exp_valid && !decode_ready)) && m_stall != 16'hFFFF)
      m_stall++;
    if (exp_req && !imem_rdy) begin
      req_wait++;
      if (req_wait == TO) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
        halt_now = 1'b1;
      end
    end else if (rdy_q) begin
      req_wait = 0;
    end
    if (accept) begin
      cur = mem[m_pc];
      n_txn++;
      $display("txn %0d: addr=%h instr=%h", n_txn, m_pc, cur);
      if (cur[15:12] == 4'hF) begin
        m_halted = 1'b1;
      end else begin
        new_adv   = 1'b1;
        adv_instr = cur;
        m_pc      = next_pc(m_pc, cur);
      end
    end
    exp_req   = !halt_now && (adv_due || (exp_req && !imem_rdy));
    exp_valid = (exp_valid && !decode_ready) || rdy_q;
    adv_due   = new_adv;
  endtask

  initial begin
    logic [15:0] v;
    int n_req, n_upd;
    reset = 1'b1; PC = 16'h0000; imem_rdy = 1'b0; imem_data = 16'h0000; decode_ready = 1'b0;
    for (int a = 0; a < 65536; a++) begin
      v = 16'($urandom);
      if (v[15:12] == 4'hF && $urandom_range(0, 49) != 0) v[15:12] = 4'h3;
      mem[a] = v;
    end
    mem[16'h0100] = 16'h1234;
    mem[16'h0200] = 16'hC0FE;
    mem[16'h0300] = 16'h1111;
    mem[16'h0500] = 16'hF000;

    // Zero-wait memory, decode always ready
    wait_max = 0; dr_pct = 100;
    do_reset(16'h0100);
    step(); check("t1_req", imem_req, 1);
    step(); check("t1_valid", instr_valid, 1); check("t1_instr", instr, 16'h1234);
    step(); check("t1_upd", updatePC, 1); check("t1_jump", jump, 0);
    step(); check("t1_next_addr", imem_addr, 16'h0101);
    repeat (6) step();

    // PC-relative jump
    do_reset(16'h0200);
    repeat (3) step();
    check("t2_jump", jump, 1); check("t2_offset", offset, 12'h0FE);
    step(); check("t2_next_addr", imem_addr, 16'h02FE);
    repeat (6) step();

    // Decode back-pressure
    dr_hold = 1'b1;
    do_reset(16'h0300);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_valid", instr_valid, 1); check("t3_instr", instr, 16'h1111); check("t3_upd", updatePC, 0);
    end
    dr_hold = 1'b0;
    step();
    step(); check("t3_upd_after", updatePC, 1);
    repeat (4) step();

    // Memory timeout
    rdy_stuck = 1'b1;
    do_reset(16'h0400);
    n_req = 0;
    for (int i = 0; i < 200 && !fetch_err; i++) begin
      step();
      if (imem_req) n_req++;
    end
    check("t4_req_cycles", n_req, TO);
    check("t4_err", fetch_err, 1); check("t4_halted", halted, 1); check("t4_req", imem_req, 0);
    repeat (5) step();
    check("t4_req_after", imem_req, 0);
    rdy_stuck = 1'b0;

    // HALT opcode, then reset restarts fetch
    do_reset(16'h0500);
    n_upd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (updatePC) n_upd++;
    end
    check("t5_upd_count", n_upd, 0); check("t5_halted", halted, 1);
    do_reset(16'h0100);
    step(); check("t5_restart_req", imem_req, 1);

    // Reset in REQ coincident with rdy
    wait_max = 2;
    do_reset(16'h0600);
    step();
    reset = 1'b1; imem_rdy = 1'b1; imem_data = 16'hBEEF;
    @(negedge Clk2);
    check("t6_instr", instr, 0); check("t6_valid", instr_valid, 0);
    check("t6_req", imem_req, 0); check("t6_upd", updatePC, 0);
`ifdef IFETCH_STALL_CNT_EN
    check("t6_stall", stall_cycles, 0);
`endif

    // Randomized latency and back-pressure
    for (int ep = 0; ep < 8; ep++) begin
      wait_max = ep % 4;
      dr_pct   = 40 + ep * 8;
      do_reset(16'($urandom));
      for (int c = 0; c < 120; c++) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
